cnt10_seq_ctrl: RTL
===================

Name: cnt10_seq_ctrl

Overview:
Sequencer for a chain of DIGITS decade counters (4-bit BCD, en/load/updown/din control, q output), digit 0 least significant.
- Loads a BCD preset, then runs the chain as one multi-digit up or down counter.
- Generates the per-digit ripple enables from the digit values.
- Stops the chain when the counter value equals a programmed target.
- Sits between the front-panel/control logic and the counter chain.

Parameters:
DIGITS, 4, number of cascaded decade counters controlled (1..8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin sequence (sampled in IDLE or DONE)
stop  in  1  abort run, return to IDLE; counters hold value
dir  in  1  0 = count up, 1 = count down; latched on accepted start
preset  in  4*DIGITS  BCD load value; latched on accepted start
target  in  4*DIGITS  BCD stop value; latched on accepted start
q_in  in  4*DIGITS  current digit values from the counter chain
cnt_en  out  DIGITS  per-digit counter enable
cnt_load  out  1  load strobe, common to all digits
cnt_updown  out  1  direction to all digits (0 up, 1 down)
cnt_din  out  4*DIGITS  load data to the digits
busy  out  1  high in LOAD and RUN
done  out  1  high while in DONE
state  out  2  IDLE=0, LOAD=1, RUN=2, DONE=3

Behaviour:
- Reset (async, rst=1): state=IDLE, dir_r=0, preset_r=0, target_r=0; all outputs 0 immediately and for as long as rst is held.
- Clamping: any preset/target digit >9 is latched as 9. Digits in the latched registers are therefore always valid BCD.
- IDLE:
  - All outputs 0.
  - start=1 and stop=0 -> LOAD; latch dir, preset, target.
- LOAD (exactly 1 cycle):
  - cnt_en all 1, cnt_load=1, cnt_din=preset_r, cnt_updown=dir_r.
  - Counters take preset at the end of this cycle. Next state is RUN unconditionally; stop is ignored in this cycle.
- RUN:
  - cnt_load=0, cnt_updown=dir_r, cnt_din=preset_r.
  - match = (q_in == target_r). If match: cnt_en=0, next state DONE.
  - Otherwise ripple enables: cnt_en[0]=1; cnt_en[i]=cnt_en[i-1] AND (q_in digit i-1 == 9 when up, == 0 when down).
  - cnt_en is combinational from state, dir_r, q_in, target_r; no registered latency.
  - Wrap-around is not special: up from all-9 goes to all-0, down from all-0 goes to all-9, and counting continues until match.
  - stop=1 in RUN -> IDLE next cycle with cnt_en=0 in that cycle (stop has priority over match).
  - start in RUN is ignored.
- DONE:
  - done=1, busy=0, cnt_en=0, cnt_load=0; counters hold.
  - start=1 and stop=0 -> LOAD, re-latching inputs.
  - stop=1 -> IDLE. start and stop together -> IDLE (stop wins).
- Latency:
  - start accepted at edge N: LOAD during cycle N+1, first RUN cycle N+2.
  - Preset→target distance d counts (modulo 10^DIGITS, in the chosen direction) gives d enabled RUN cycles plus 1 match cycle, then DONE.
  - preset == target: one RUN cycle with match, no count, DONE next.
- Inputs preset/target/dir changed after start have no effect until the next accepted start.
- Reset mid-run: counters are not touched by this block (cnt_en/cnt_load forced 0); their own contents stay undefined to this block until the next LOAD.

Test Plan:
- Reset mid-RUN (DIGITS=2, up, preset 00, target 50, rst pulse at count 23) -> state=0, cnt_en=0, cnt_load=0, busy=0, done=0 asynchronously. A following start with preset 00 reloads the chain to 00.
- DIGITS=2, dir=0, preset 07, target 12, start pulse -> 1 LOAD cycle (cnt_load=1, cnt_din=0x07); RUN: q_in=07,08,09,10,11 with cnt_en=01,01,11,01,01; q_in=12 gives cnt_en=00; then DONE, done=1, q_in held at 12.
- DIGITS=2, dir=1, preset 01, target 98 -> counts 01,00,99,98 (cnt_en=01,11,01 on the enabled cycles); wrap through 00→99 works; done at 98 after 3 counts + 1 match cycle.
- preset=target=0x35 -> LOAD, one RUN cycle with cnt_en=00, DONE; no count occurs. Preset digit 0xC with target 0x09 (DIGITS=1) -> cnt_din=0x9, immediate DONE.
- stop asserted at RUN count 0x40 (target 0x99) -> cnt_en=0 that cycle, IDLE next, q_in stays 0x40. start+stop together in DONE -> IDLE.
- start held high continuously -> after DONE, re-enters LOAD next cycle and repeats the sequence. start pulses during RUN are ignored, and the target is not re-latched.

Source files
------------

// File: rtl/cnt10_seq_ctrl.sv
// Sequencer for a chain of BCD decade counters:
// preset load, ripple-enable counting, stop on target.
module cnt10_seq_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic [4*DIGITS-1:0] preset,
  input  logic [4*DIGITS-1:0] target,
  input  logic [4*DIGITS-1:0] q_in,
  output logic [DIGITS-1:0]   cnt_en,
  output logic                cnt_load,
  output logic                cnt_updown,
  output logic [4*DIGITS-1:0] cnt_din,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                dir_q, dir_d;
  logic [4*DIGITS-1:0] preset_q, preset_d;
  logic [4*DIGITS-1:0] target_q, target_d;

  logic                latch;
  logic                match;
  logic [DIGITS-1:0]   rip;

  function automatic logic [4*DIGITS-1:0] clamp(
    input logic [4*DIGITS-1:0] v
  );
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i+:4] > 4'd9) r[4*i+:4] = 4'd9;
    end
    return r;
  endfunction

  assign match = (q_in == target_q);
  assign state = state_q;

  // Ripple enables: a digit steps only when all lower digits roll over.
  always_comb begin
    logic carry;
    rip   = '0;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      rip[i] = carry;
      carry  = carry & (dir_q ? (q_in[4*i+:4] == 4'd0)
                              : (q_in[4*i+:4] == 4'd9));
    end
  end

  // Next-state, input latching and chain control outputs.
  always_comb begin
    state_d    = state_q;
    latch      = 1'b0;
    cnt_en     = '0;
    cnt_load   = 1'b0;
    cnt_updown = 1'b0;
    cnt_din    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_LOAD;
          latch   = 1'b1;
        end
      end
      S_LOAD: begin
        cnt_en     = '1;
        cnt_load   = 1'b1;
        cnt_updown = dir_q;
        cnt_din    = preset_q;
        busy       = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN: begin
        cnt_updown = dir_q;
        cnt_din    = preset_q;
        busy       = 1'b1;
        if (stop) begin
          state_d = S_IDLE;
        end else if (match) begin
          state_d = S_DONE;
        end else begin
          cnt_en = rip;
        end
      end
      S_DONE: begin
        cnt_updown = dir_q;
        cnt_din    = preset_q;
        done       = 1'b1;
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_LOAD;
          latch   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on an accepted start; digits clamped to 9.
  always_comb begin
    dir_d    = dir_q;
    preset_d = preset_q;
    target_d = target_q;
    if (latch) begin
      dir_d    = dir;
      preset_d = clamp(preset);
      target_d = clamp(target);
    end
  end

  // State and latched operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      preset_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      preset_q <= preset_d;
      target_q <= target_d;
    end
  end

endmodule
